// File: rtl/mem_row_fetcher.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : mem_row_fetcher
// Description : Fetches NUM_WORDS 64-bit words over an Avalon-MM read port
//               (one read outstanding) and serialises each word MSB-first
//               into a valid/ready byte stream tagged with row/column.
//               Optional read watchdog enabled by the FETCH_TIMEOUT_EN macro.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_row_fetcher #(
  parameter int          NUM_WORDS      = 9,
  parameter logic [31:0] BASE_ADDR      = 32'd0,
  parameter int          TIMEOUT_CYCLES = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  output logic [31:0] address,
  output logic        read,
  input  logic        waitrequest,
  input  logic [63:0] readdata,
  input  logic        readdatavalid,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [7:0]  out_data,
  output logic [3:0]  out_row,
  output logic [2:0]  out_col,
  output logic        out_last,
  output logic        busy,
  output logic        done,
  output logic        err
);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_REQ       = 3'd1,
    S_WAIT_DATA = 3'd2,
    S_SHIFT     = 3'd3,
    S_DONE      = 3'd4,
    S_ERROR     = 3'd5
  } state_t;

  localparam logic [3:0] LAST_WORD = 4'(NUM_WORDS - 1);

  state_t      state;
  logic [3:0]  word_idx;
  logic [2:0]  byte_idx;
  logic [63:0] shreg;

  // The stream fields are direct views of registered state, so they are
  // glitch-free and naturally hold while the consumer stalls.
  assign out_data = shreg[63:56];
  assign out_row  = word_idx;
  assign out_col  = byte_idx;

`ifdef FETCH_TIMEOUT_EN
  localparam int            TW       = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

  logic [TW-1:0] tmo_cnt;
  logic          err_r;

  assign err = err_r;
`else
  logic unused_cfg;

  // Without the watchdog the limit has no meaning; err can never assert.
  assign unused_cfg = (TIMEOUT_CYCLES != 0);
  assign err        = 1'b0;
`endif

  // Fetch/serialise controller; every output is registered here.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      word_idx  <= 4'd0;
      byte_idx  <= 3'd0;
      shreg     <= 64'd0;
      address   <= 32'd0;
      read      <= 1'b0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
`ifdef FETCH_TIMEOUT_EN
      tmo_cnt   <= '0;
      err_r     <= 1'b0;
`endif
    end else begin
      case (state)
        S_IDLE, S_DONE, S_ERROR: begin
          if (start) begin
            state    <= S_REQ;
            word_idx <= 4'd0;
            done     <= 1'b0;
            busy     <= 1'b1;
`ifdef FETCH_TIMEOUT_EN
            err_r    <= 1'b0;
`endif
          end else if (state == S_DONE) begin
            // done rises one cycle after the final byte transfer.
            done <= 1'b1;
          end
        end

        S_REQ: begin
          // First cycle launches the request; afterwards hold it until
          // the slave stops stalling.
          if (!read) begin
            read    <= 1'b1;
            address <= BASE_ADDR + {28'd0, word_idx};
          end else if (!waitrequest) begin
            read  <= 1'b0;
            state <= S_WAIT_DATA;
          end
        end

        S_WAIT_DATA: begin
          if (readdatavalid) begin
            shreg    <= readdata;
            byte_idx <= 3'd0;
            state    <= S_SHIFT;
          end
        end

        S_SHIFT: begin
          if (!out_valid) begin
            out_valid <= 1'b1;
            out_last  <= 1'b0;
          end else if (out_ready) begin
            shreg <= {shreg[55:0], 8'h00};
            if (byte_idx == 3'd7) begin
              // byte_idx stays at 7 until the next word is loaded.
              out_valid <= 1'b0;
              out_last  <= 1'b0;
              if (word_idx == LAST_WORD) begin
                state <= S_DONE;
                busy  <= 1'b0;
              end else begin
                word_idx <= word_idx + 4'd1;
                state    <= S_REQ;
              end
            end else begin
              byte_idx <= byte_idx + 3'd1;
              out_last <= (byte_idx == 3'd6) && (word_idx == LAST_WORD);
            end
          end
        end

        default: begin
          state <= S_IDLE;
        end
      endcase

`ifdef FETCH_TIMEOUT_EN
      // Watchdog counts stalled cycles in REQ/WAIT_DATA and restarts on
      // every state entry; progress on the same edge takes priority.
      if ((state == S_REQ && !(read && !waitrequest)) ||
          (state == S_WAIT_DATA && !readdatavalid)) begin
        if (tmo_cnt == TMO_LAST) begin
          state     <= S_ERROR;
          err_r     <= 1'b1;
          read      <= 1'b0;
          busy      <= 1'b0;
          out_valid <= 1'b0;
          tmo_cnt   <= '0;
        end else begin
          tmo_cnt <= tmo_cnt + 1'b1;
        end
      end else begin
        tmo_cnt <= '0;
      end
`endif
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mem_row_fetcher.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_mem_row_fetcher
// Description : Scoreboard bench for mem_row_fetcher with a behavioural
//               Avalon ROM slave (10-cycle waitrequest). Define
//               FETCH_TIMEOUT_EN to also exercise the read watchdog.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_row_fetcher;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [31:0] address;
  logic        read;
  logic        waitrequest = 1'b1;
  logic [63:0] readdata = 64'd0;
  logic        readdatavalid = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [7:0]  out_data;
  logic [3:0]  out_row;
  logic [2:0]  out_col;
  logic        out_last;
  logic        busy;
  logic        done;
  logic        err;

  always #5 clk = ~clk;

  mem_row_fetcher #(
    .NUM_WORDS     (9),
    .BASE_ADDR     (32'd0),
    .TIMEOUT_CYCLES(64)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .address      (address),
    .read         (read),
    .waitrequest  (waitrequest),
    .readdata     (readdata),
    .readdatavalid(readdatavalid),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_data     (out_data),
    .out_row      (out_row),
    .out_col      (out_col),
    .out_last     (out_last),
    .busy         (busy),
    .done         (done),
    .err          (err)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h @%0t", tag, got, exp, $time);
    end
  endtask

  // ROM word a holds bytes {a,1} {a,2} .. {a,8} (nibbles), MSB first.
  function automatic logic [63:0] rom(input logic [31:0] a);
    logic [63:0] w;
    for (int j = 0; j < 8; j++) w[63-8*j -: 8] = {a[3:0], 4'(j + 1)};
    return w;
  endfunction

  // Expected stream entry packed as {last, row, col, data}.
  function automatic logic [15:0] exp_byte(input int r, input int c);
    return {(r == 8 && c == 7), 4'(r), 3'(c), 4'(r), 4'(c + 1)};
  endfunction

  logic [15:0] sb[$];

  task automatic push_run();
    for (int r = 0; r < 9; r++)
      for (int c = 0; c < 8; c++) sb.push_back(exp_byte(r, c));
  endtask

  // Slave model / ready control / stream monitor state
  int          wr_cycles = 10;
  bit          no_data   = 1'b0;
  int          wcnt      = 0;
  logic        prev_read = 1'b0;
  logic        prev_wr   = 1'b1;
  logic [31:0] prev_addr = 32'd0;
  int          acc_word  = 0;
  int          acc_total = 0;
  logic [31:0] max_addr  = 32'd0;
  int          stall_cnt = 0;

  // All negedge-side behaviour: Avalon ROM slave, out_ready policy, scoreboard.
  always @(negedge clk) begin : neg_side
    logic accept;
    if (rst) begin
      waitrequest   = 1'b1;
      readdatavalid = 1'b0;
      wcnt          = 0;
      prev_read     = 1'b0;
      prev_wr       = 1'b1;
      out_ready     = 1'b1;
    end else begin
      // Acceptance happened at the posedge just passed iff read was held
      // high and waitrequest was low going into it.
      accept        = prev_read && !prev_wr;
      readdatavalid = 1'b0;
      if (start && !busy) acc_word = 0;
      if (accept) begin
        check_eq("acc_addr", prev_addr, acc_word);
        if (prev_addr > max_addr) max_addr = prev_addr;
        acc_word++;
        acc_total++;
        if (!no_data) begin
          readdatavalid = 1'b1;
          readdata      = rom(prev_addr);
        end
      end else if (prev_read && prev_wr && read) begin
        check_eq("addr_hold", address, prev_addr);
      end
      if (read) begin
        if (wcnt < wr_cycles) begin
          waitrequest = 1'b1;
          wcnt++;
        end else begin
          waitrequest = 1'b0;
        end
      end else begin
        waitrequest = 1'b1;
        wcnt        = 0;
      end
      prev_read = read;
      prev_wr   = waitrequest;
      prev_addr = address;

      if (stall_cnt > 0 && out_valid && out_row == 4'd0 && out_col == 3'd3) begin
        out_ready = 1'b0;
        stall_cnt--;
      end else begin
        out_ready = 1'b1;
      end

      if (out_valid) begin
        if (sb.size() == 0) begin
          check_eq("extra_byte", sb.size(), 1);
        end else begin
          check_eq(out_ready ? "byte" : "hold", {out_last, out_row, out_col, out_data}, sb[0]);
          if (out_ready) void'(sb.pop_front());
        end
      end
    end
  end

  task automatic do_start();
    @(posedge clk);
    #1 start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (done) break;
    end
    check_eq("done", done, 1);
    check_eq("busy_at_done", busy, 0);
    check_eq("sb_drained", sb.size(), 0);
  endtask

  task automatic wait_row(input logic [3:0] row, input int budget);
    bit found = 1'b0;
    for (int i = 0; i < budget && !found; i++) begin
      @(negedge clk);
      if (out_valid && out_row == row) found = 1'b1;
    end
    check_eq("row_seen", found, 1);
  endtask

  function automatic logic [52:0] out_vec();
    return {address, read, out_valid, out_data, out_row, out_col, out_last, busy, done, err};
  endfunction

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin : stim
    int a0;
    // Reset state
    repeat (3) @(posedge clk);
    #1 check_eq("reset_outputs", out_vec(), 0);
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1 check_eq("idle_quiet", {busy, read, out_valid, done}, 0);

    // Full run with a 5-cycle consumer stall on byte 0x04 and 10-cycle waits
    stall_cnt = 5;
    a0 = acc_total;
    do_start();
    check_eq("read_latency_n", read, 0);
    check_eq("busy_after_start", busy, 1);
    push_run();
    @(posedge clk);
    #1 check_eq("read_latency_n1", {read, address}, {1'b1, 32'd0});
    wait_done(3000);
    check_eq("acc_count_a", acc_total - a0, 9);
    check_eq("max_addr_le_8", max_addr <= 32'd8, 1);
    check_eq("stall_applied", stall_cnt, 0);

    // Asynchronous reset in the middle of row 4, then a clean rerun
    do_start();
    push_run();
    wait_row(4'd4, 3000);
    @(negedge clk);
    #2 rst = 1'b1;
    #1 check_eq("rst_async", out_vec(), 0);
    sb.delete();
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b0;
    repeat (5) begin
      @(negedge clk);
      check_eq("post_rst_quiet", {out_valid, read, busy}, 0);
    end
    a0 = acc_total;
    do_start();
    push_run();
    wait_done(3000);
    check_eq("acc_count_b", acc_total - a0, 9);

    // Restart from DONE; a start pulse mid-run must be ignored
    a0 = acc_total;
    do_start();
    check_eq("done_cleared", {done, busy}, 2'b01);
    push_run();
    wait_row(4'd2, 3000);
    do_start();
    wait_done(3000);
    check_eq("acc_count_c", acc_total - a0, 9);

`ifdef FETCH_TIMEOUT_EN
    // Slave never returns data: watchdog fires, next start retries addr 0
    no_data = 1'b1;
    do_start();
    repeat (60) @(negedge clk);
    check_eq("err_early", err, 0);
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (err) break;
    end
    check_eq("err_state", {err, read, busy, out_valid}, 4'b1000);
    no_data = 1'b0;
    a0 = acc_total;
    do_start();
    check_eq("err_cleared", err, 0);
    push_run();
    wait_done(3000);
    check_eq("acc_count_d", acc_total - a0, 9);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
